// File: rtl/lma_pkg.sv
// rtl/lma_pkg.sv - shared defaults, csel encodings and requester indices for the layer-memory arbiter
package lma_pkg;

    localparam int LMA_NREQ = 3;
    localparam int LMA_AW   = 12;
    localparam int LMA_DW   = 20;
    localparam int LMA_SW   = 3;

    typedef enum logic [2:0] {
        CSEL_NONE = 3'd0,
        L0_K0     = 3'd1,
        L0_K1     = 3'd2,
        L1_K0     = 3'd3,
        L1_K1     = 3'd4,
        L2_OUT    = 3'd5
    } csel_e;

    localparam int REQ_CONV = 0;
    localparam int REQ_POOL = 1;
    localparam int REQ_FLAT = 2;

    // Width of a round-robin pointer able to name every requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lma_rr_pick.sv
// rtl/lma_rr_pick.sv - rotate-priority one-hot picker: first requester strictly after the pointer wins
module lma_rr_pick
    import lma_pkg::*;
#(
    parameter int NREQ = LMA_NREQ,
    parameter int PW   = ptr_width(LMA_NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    // Scan from pointer+1 around to the pointer itself; the last-served requester ranks lowest.
    always_comb begin : pick
        int   idx;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_mem_arbiter.sv
// rtl/layer_mem_arbiter.sv - round-robin share of the layer-memory port; LMA_BURST_LOCK_EN enables burst lock
module layer_mem_arbiter
    import lma_pkg::*;
#(
    parameter int NREQ = LMA_NREQ,
    parameter int AW   = LMA_AW,
    parameter int DW   = LMA_DW,
    parameter int SW   = LMA_SW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*SW-1:0]   sel,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic [SW-1:0]        csel,
    output logic                 cwr,
    output logic [AW-1:0]        caddr_wr,
    output logic [DW-1:0]        cdata_wr,
    output logic                 crd,
    output logic [AW-1:0]        caddr_rd,
    input  logic [DW-1:0]        cdata_rd
);

    localparam int PW = ptr_width(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] rr_gnt;
    logic [NREQ-1:0] gnt_sel;
    logic [PW-1:0]   gidx;
    logic            any_gnt;
    logic            lock_hold;

    logic [SW-1:0]   csel_q, csel_d;
    logic            cwr_q, cwr_d;
    logic            crd_q, crd_d;
    logic [AW-1:0]   caddr_wr_q, caddr_wr_d;
    logic [AW-1:0]   caddr_rd_q, caddr_rd_d;
    logic [DW-1:0]   cdata_wr_q, cdata_wr_d;
    logic [NREQ-1:0] rd_pend_q, rd_pend_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;

    lma_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt)
    );

`ifdef LMA_BURST_LOCK_EN
    logic lock_q, lock_d;

    // The last-granted requester keeps the port while it holds both lock and req.
    assign lock_hold = lock_q && req[ptr_q] && lock[ptr_q];
    assign lock_d    = any_gnt && lock[gidx];

    // Remember whether the most recent grant went to a locking requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_lock;

    assign lock_hold   = 1'b0;
    assign unused_lock = ^lock;
`endif

    // Final grant: lock holder first, otherwise round-robin; nothing is granted while in reset.
    always_comb begin
        gnt_sel = '0;
        if (reset) begin
            gnt_sel = '0;
        end else if (lock_hold) begin
            gnt_sel = NREQ'(1) << ptr_q;
        end else begin
            gnt_sel = rr_gnt;
        end
    end

    // Encode the one-hot grant so the winner's fields can be muxed onto the port.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_sel[i]) begin
                gidx = PW'(i);
            end
        end
    end

    assign any_gnt = |gnt_sel;
    assign ptr_d   = any_gnt ? gidx : ptr_q;

    // Next memory-side state: strobes are single-cycle, address/data/select hold between transactions.
    always_comb begin
        csel_d     = csel_q;
        cwr_d      = 1'b0;
        crd_d      = 1'b0;
        caddr_wr_d = caddr_wr_q;
        caddr_rd_d = caddr_rd_q;
        cdata_wr_d = cdata_wr_q;
        rd_pend_d  = gnt_sel & ~we;
        rvalid_d   = rd_pend_q;
        if (any_gnt) begin
            csel_d = sel[int'(gidx)*SW +: SW];
            if (we[gidx]) begin
                cwr_d      = 1'b1;
                caddr_wr_d = addr[int'(gidx)*AW +: AW];
                cdata_wr_d = wdata[int'(gidx)*DW +: DW];
            end else begin
                crd_d      = 1'b1;
                caddr_rd_d = addr[int'(gidx)*AW +: AW];
            end
        end
    end

    // Pointer, registered memory port and the two-stage read-return pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= PW'(NREQ - 1);
            csel_q     <= SW'(CSEL_NONE);
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            rd_pend_q  <= '0;
            rvalid_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            csel_q     <= csel_d;
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
            caddr_wr_q <= caddr_wr_d;
            caddr_rd_q <= caddr_rd_d;
            cdata_wr_q <= cdata_wr_d;
            rd_pend_q  <= rd_pend_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign gnt      = gnt_sel;
    assign csel     = csel_q;
    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;
    assign cdata_wr = cdata_wr_q;
    assign rvalid   = rvalid_q;
    assign rdata    = cdata_rd;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// tb/tb_layer_mem_arbiter.sv - scoreboard bench for the layer-memory arbiter
module tb_layer_mem_arbiter;
    import lma_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 20;
    localparam int SW   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req, we, lock;
    logic [NREQ*SW-1:0] sel;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic [SW-1:0]     csel;
    logic              cwr, crd;
    logic [AW-1:0]     caddr_wr, caddr_rd;
    logic [DW-1:0]     cdata_wr;
    logic [DW-1:0]     cdata_rd = '0;

    layer_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
        .sel(sel), .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          cwr;
        logic          crd;
        logic [SW-1:0] csel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_t;

    typedef struct packed {
        logic [NREQ-1:0] rv;
        logic [DW-1:0]   data;
    } rv_t;

    logic [NREQ-1:0] q_gnt[$];
    mem_t            q_mem[$];
    rv_t             q_rv[$];
    logic [54:0]     q_rst[$];

    int n_vec = 0;
    int n_err = 0;

    // Memory responder: fixed contents for a few addresses, pattern elsewhere.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 12'h040) return 20'h12345;
        return {8'hA5, a};
    endfunction

    always @(posedge clk) begin
        if (crd) cdata_rd <= mem_val(caddr_rd);
    end

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [63:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %h expected no output", nm, act);
    endtask

    logic [54:0] act_rst;
    mem_t        act_mem;
    rv_t         act_rv;

    // Monitor: pop and compare whenever the DUT presents something.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            act_rst = {gnt, rvalid, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr};
            if (q_rst.size() == 0) unexpected("reset_state", 64'(act_rst));
            else cmp("reset_state", 64'(act_rst), 64'(q_rst.pop_front()));
        end else begin
            if (gnt !== '0) begin
                if (q_gnt.size() == 0) unexpected("gnt", 64'(gnt));
                else cmp("gnt", 64'(gnt), 64'(q_gnt.pop_front()));
            end
            if (cwr !== 1'b0 || crd !== 1'b0) begin
                act_mem.cwr  = cwr;
                act_mem.crd  = crd;
                act_mem.csel = csel;
                act_mem.addr = cwr ? caddr_wr : caddr_rd;
                act_mem.data = cwr ? cdata_wr : '0;
                if (q_mem.size() == 0) unexpected("mem_port", 64'(act_mem));
                else cmp("mem_port", 64'(act_mem), 64'(q_mem.pop_front()));
            end
            if (rvalid !== '0) begin
                act_rv.rv   = rvalid;
                act_rv.data = rdata;
                if (q_rv.size() == 0) unexpected("read_return", 64'(act_rv));
                else cmp("read_return", 64'(act_rv), 64'(q_rv.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tx(input int i, input logic w, input logic [SW-1:0] s,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
        req[i]            = 1'b1;
        we[i]             = w;
        lock[i]           = l;
        sel[i*SW +: SW]   = s;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic drop(input int i);
        req[i]  = 1'b0;
        lock[i] = 1'b0;
    endtask

    task automatic exp_wr(input logic [SW-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_t m;
        m.cwr = 1'b1; m.crd = 1'b0; m.csel = s; m.addr = a; m.data = d;
        q_mem.push_back(m);
    endtask

    task automatic exp_rd(input logic [SW-1:0] s, input logic [AW-1:0] a);
        mem_t m;
        m.cwr = 1'b0; m.crd = 1'b1; m.csel = s; m.addr = a; m.data = '0;
        q_mem.push_back(m);
    endtask

    task automatic exp_rv(input logic [NREQ-1:0] rv, input logic [DW-1:0] d);
        rv_t r;
        r.rv = rv; r.data = d;
        q_rv.push_back(r);
    endtask

    // Hold reset over n falling edges, expecting every output at its reset value each time.
    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int j = 0; j < n; j++) begin
            q_rst.push_back('0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        int          k[3];
        int          r0, r1;
        logic [2:0]  seq[6];

        reset = 1'b1;
        req = '0; we = '0; lock = '0; sel = '0; addr = '0; wdata = '0;
        do_reset(2);

        // All three write continuously: from pointer=2 the order is 0,1,2,0,1,2.
        k = '{0, 0, 0};
        for (int c = 0; c < 6; c++) begin
            int g;
            for (int i = 0; i < 3; i++)
                set_tx(i, 1'b1, SW'(i + 1), 12'h100 + AW'(i*16 + k[i]), 20'hA0000 + DW'(i*256 + k[i]), 1'b0);
            g = c % 3;
            q_gnt.push_back(NREQ'(1) << g);
            exp_wr(SW'(g + 1), 12'h100 + AW'(g*16 + k[g]), 20'hA0000 + DW'(g*256 + k[g]));
            tick();
            k[g]++;
        end
        drop(0); drop(1); drop(2);

        // Single write from requester 0.
        set_tx(REQ_CONV, 1'b1, L0_K0, 12'h005, 20'h00ABC, 1'b0);
        q_gnt.push_back(3'b001);
        exp_wr(L0_K0, 12'h005, 20'h00ABC);
        tick();
        drop(REQ_CONV);

        // Read from requester 1: strobe at t+1, data back at t+2.
        set_tx(REQ_POOL, 1'b0, L1_K0, 12'h040, 20'h0, 1'b0);
        q_gnt.push_back(3'b010);
        exp_rd(L1_K0, 12'h040);
        exp_rv(3'b010, 20'h12345);
        tick();
        drop(REQ_POOL);
        tick(); tick();

        // Bring the pointer to 0 with a lone requester-0 write.
        set_tx(REQ_CONV, 1'b1, L0_K1, 12'h0A0, 20'h0BEEF, 1'b0);
        q_gnt.push_back(3'b001);
        exp_wr(L0_K1, 12'h0A0, 20'h0BEEF);
        tick();
        drop(REQ_CONV);

        // Pointer=0, requester 0 write and requester 2 read together: 2 wins first.
        set_tx(REQ_CONV, 1'b1, L0_K1, 12'h0A1, 20'h0F00D, 1'b0);
        set_tx(REQ_FLAT, 1'b0, L2_OUT, 12'h3FF, 20'h0, 1'b0);
        q_gnt.push_back(3'b100);
        exp_rd(L2_OUT, 12'h3FF);
        exp_rv(3'b100, 20'hA53FF);
        tick();
        drop(REQ_FLAT);
        q_gnt.push_back(3'b001);
        exp_wr(L0_K1, 12'h0A1, 20'h0F00D);
        tick();
        drop(REQ_CONV);
        tick(); tick();

        // Read granted, then reset during its strobe cycle: the read must vanish.
        set_tx(REQ_POOL, 1'b0, L1_K1, 12'h777, 20'h0, 1'b0);
        q_gnt.push_back(3'b010);
        tick();
        drop(REQ_POOL);
        set_tx(REQ_FLAT, 1'b1, L2_OUT, 12'h222, 20'h22222, 1'b0);
        do_reset(1);
        set_tx(REQ_CONV, 1'b1, L0_K0, 12'h111, 20'h11111, 1'b0);
        set_tx(REQ_POOL, 1'b1, L0_K1, 12'h333, 20'h33333, 1'b0);
        q_gnt.push_back(3'b001);
        exp_wr(L0_K0, 12'h111, 20'h11111);
        tick();
        drop(REQ_CONV);
        q_gnt.push_back(3'b010);
        exp_wr(L0_K1, 12'h333, 20'h33333);
        tick();
        drop(REQ_POOL);
        q_gnt.push_back(3'b100);
        exp_wr(L2_OUT, 12'h222, 20'h22222);
        tick();
        drop(REQ_FLAT);
        tick(); tick();

        // Requester 0 locks for 4 writes while requester 1 has 2 writes pending.
`ifdef LMA_BURST_LOCK_EN
        seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010};
`else
        seq = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b001};
`endif
        r0 = 4;
        r1 = 2;
        for (int c = 0; c < 6; c++) begin
            if (r0 > 0) set_tx(REQ_CONV, 1'b1, L0_K0, 12'h600 + AW'(r0), 20'h60000 + DW'(r0), 1'b1);
            if (r1 > 0) set_tx(REQ_POOL, 1'b1, L0_K1, 12'h610 + AW'(r1), 20'h61000 + DW'(r1), 1'b0);
            q_gnt.push_back(seq[c]);
            if (seq[c] == 3'b001) begin
                exp_wr(L0_K0, 12'h600 + AW'(r0), 20'h60000 + DW'(r0));
                r0--;
            end else begin
                exp_wr(L0_K1, 12'h610 + AW'(r1), 20'h61000 + DW'(r1));
                r1--;
            end
            tick();
            if (r0 == 0) drop(REQ_CONV);
            if (r1 == 0) drop(REQ_POOL);
        end
        tick(); tick(); tick();

        cmp("gnt_outstanding", 64'(q_gnt.size()), 64'd0);
        cmp("mem_outstanding", 64'(q_mem.size()), 64'd0);
        cmp("rv_outstanding",  64'(q_rv.size()),  64'd0);
        cmp("rst_outstanding", 64'(q_rst.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
